mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I datapath. It drives the shared ALU, extender, NPC unit, register file and a single unified instruction/data memory port, using the team's EXTOp/ALUOp/NPCOp/WDSel encodings. Each instruction is split into FETCH/DECODE/EXEC/MEM/WB states, with a ready handshake toward memory. It also keeps a retired-instruction counter.

---
 rtl/mc_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over one unified memory port,
// driving the shared ALU/EXT/NPC/regfile controls and counting retired instructions.
`timescale 1ns/1ps
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Op,
  input  logic [6:0]  Funct7,
  input  logic [2:0]  Funct3,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IRWrite,
  output logic        MDRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [5:0]  EXTOp,
  output logic [4:0]  ALUOp,
  output logic [2:0]  NPCOp,
  output logic        ALUSrc,
  output logic [1:0]  WDSel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        retire,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_ILL,
    C_ALU,
    C_LW,
    C_SW,
    C_BEQ,
    C_JAL
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [5:0] EXT_NONE  = 6'b000000;
  localparam logic [5:0] EXT_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_I     = 6'b010000;
  localparam logic [5:0] EXT_S     = 6'b001000;
  localparam logic [5:0] EXT_B     = 6'b000100;
  localparam logic [5:0] EXT_U     = 6'b000010;
  localparam logic [5:0] EXT_J     = 6'b000001;

  localparam logic [4:0] ALU_NOP  = 5'b00000;
  localparam logic [4:0] ALU_LUI  = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b01010;
  localparam logic [4:0] ALU_SLTU = 5'b01011;
  localparam logic [4:0] ALU_XOR  = 5'b01100;
  localparam logic [4:0] ALU_OR   = 5'b01101;
  localparam logic [4:0] ALU_AND  = 5'b01110;
  localparam logic [4:0] ALU_SLL  = 5'b01111;
  localparam logic [4:0] ALU_SRL  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b10001;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  state_e      state_q, state_d;
  logic [31:0] instret_q;

  cls_e        cls;
  logic [5:0]  dec_ext;
  logic [4:0]  dec_alu;
  logic        dec_src;
  logic [1:0]  dec_wd;

  logic        f7_base, f7_alt, i_shift, r_ok, i_ok, shift_alt;

  function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [4:0] r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  assign f7_base   = (Funct7 == 7'b0000000);
  assign f7_alt    = (Funct7 == 7'b0100000);
  assign i_shift   = (Funct3 == 3'b001) || (Funct3 == 3'b101);
  assign r_ok      = f7_base || (f7_alt && ((Funct3 == 3'b000) || (Funct3 == 3'b101)));
  // Non-shift I-type ops carry immediate bits in Funct7, so only shifts constrain it.
  assign i_ok      = !i_shift || f7_base || (f7_alt && (Funct3 == 3'b101));
  assign shift_alt = (Funct3 == 3'b101) && f7_alt;

  always_comb begin
    cls     = C_ILL;
    dec_ext = EXT_NONE;
    dec_alu = ALU_NOP;
    dec_src = 1'b0;
    dec_wd  = WD_ALU;
    case (Op)
      OP_R: begin
        if (r_ok) begin
          cls     = C_ALU;
          dec_alu = alu_of(Funct3, Funct7[5]);
        end
      end
      OP_I: begin
        if (i_ok) begin
          cls     = C_ALU;
          dec_alu = alu_of(Funct3, shift_alt);
          dec_ext = i_shift ? EXT_SHAMT : EXT_I;
          dec_src = 1'b1;
        end
      end
      OP_LOAD: begin
        if (Funct3 == 3'b010) begin
          cls     = C_LW;
          dec_ext = EXT_I;
          dec_alu = ALU_ADD;
          dec_src = 1'b1;
          dec_wd  = WD_MEM;
        end
      end
      OP_STORE: begin
        if (Funct3 == 3'b010) begin
          cls     = C_SW;
          dec_ext = EXT_S;
          dec_alu = ALU_ADD;
          dec_src = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (Funct3 == 3'b000) begin
          cls     = C_BEQ;
          dec_ext = EXT_B;
          dec_alu = ALU_SUB;
        end
      end
      OP_JAL: begin
        cls     = C_JAL;
        dec_ext = EXT_J;
        dec_wd  = WD_PC;
      end
      OP_LUI: begin
        cls     = C_ALU;
        dec_ext = EXT_U;
        dec_alu = ALU_LUI;
        dec_src = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IRWrite  = 1'b0;
    MDRWrite = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    NPCOp    = NPC_PLUS4;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        IRWrite = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        if (cls == C_ILL) begin
          illegal = 1'b1;
          PCWrite = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cls)
          C_ALU:       state_d = WB;
          C_LW, C_SW:  state_d = MEM;
          C_BEQ: begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
            retire  = 1'b1;
            state_d = FETCH;
          end
          C_JAL: begin
            RegWrite = 1'b1;
            PCWrite  = 1'b1;
            NPCOp    = NPC_JUMP;
            retire   = 1'b1;
            state_d  = FETCH;
          end
          default:     state_d = FETCH;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == C_SW);
        if (mem_ready) begin
          if (cls == C_LW) begin
            MDRWrite = 1'b1;
            state_d  = WB;
          end else begin
            PCWrite = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // The state register already sits in FETCH under reset; this also silences FETCH's mem_req.
    if (reset) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      IRWrite  = 1'b0;
      MDRWrite = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
      retire   = 1'b0;
    end
  end

  assign EXTOp   = (state_q == FETCH) ? '0 : dec_ext;
  assign ALUOp   = (state_q == FETCH) ? '0 : dec_alu;
  assign ALUSrc  = (state_q == FETCH) ? 1'b0 : dec_src;
  assign WDSel   = (state_q == FETCH) ? '0 : dec_wd;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized scoreboard bench for mc_ctrl: per-instruction expectations are queued at issue
// and compared by a monitor when the instruction retires or is flagged illegal.
`timescale 1ns/1ps
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  Op = '0;
  logic [6:0]  Funct7 = '0;
  logic [2:0]  Funct3 = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, IRWrite, MDRWrite, PCWrite, RegWrite;
  logic [5:0]  EXTOp;
  logic [4:0]  ALUOp;
  logic [2:0]  NPCOp;
  logic        ALUSrc;
  logic [1:0]  WDSel;
  logic [2:0]  state;
  logic        illegal, retire;
  logic [31:0] instret;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct7(Funct7), .Funct3(Funct3),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .IRWrite(IRWrite), .MDRWrite(MDRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .ALUSrc(ALUSrc), .WDSel(WDSel),
    .state(state), .illegal(illegal), .retire(retire), .instret(instret)
  );

  typedef struct {
    bit          ill;
    logic [5:0]  ext;
    logic [4:0]  alu;
    logic        src;
    logic [1:0]  wd;
    int          regw;
    int          mdr;
    int          nreq;
    int          nwe;
    logic [2:0]  npc;
    int          cycles;
    logic [31:0] instret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_instret = '0;

  // ALU operation by funct3 for the base (Funct7 bit 5 clear) R/I variants
  logic [4:0] alu_tab [8] = '{5'b00011, 5'b01111, 5'b01010, 5'b01011,
                              5'b01100, 5'b10000, 5'b01101, 5'b01110};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic z, input int fw, input int mw);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    e = '{default: 0};
    e.ill     = 1'b1;
    e.instret = model_instret;
    e.nreq    = fw + 1;
    e.cycles  = 2 + fw;
    case (op)
      7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        e.ill = 1'b0; e.regw = 1; e.cycles = 4 + fw;
        e.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? 5'b00100 : 5'b10001) : alu_tab[f3];
      end
      7'b0010011: if ((f3 != 3'd1 && f3 != 3'd5) || (f3 == 3'd1 && f7 == 7'h00) ||
                      (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20))) begin
        e.ill = 1'b0; e.regw = 1; e.cycles = 4 + fw; e.src = 1'b1;
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 5'b10001 : alu_tab[f3];
        e.ext = (f3 == 3'd1 || f3 == 3'd5) ? 6'b100000 : 6'b010000;
      end
      7'b0000011: if (f3 == 3'd2) begin
        e.ill = 1'b0; e.regw = 1; e.mdr = 1; e.src = 1'b1; e.wd = 2'b01;
        e.alu = 5'b00011; e.ext = 6'b010000;
        e.cycles = 5 + fw + mw; e.nreq = fw + mw + 2;
      end
      7'b0100011: if (f3 == 3'd2) begin
        e.ill = 1'b0; e.src = 1'b1; e.alu = 5'b00011; e.ext = 6'b001000;
        e.cycles = 4 + fw + mw; e.nreq = fw + mw + 2; e.nwe = mw + 1;
      end
      7'b1100011: if (f3 == 3'd0) begin
        e.ill = 1'b0; e.alu = 5'b00100; e.ext = 6'b000100; e.cycles = 3 + fw;
        e.npc = {2'b00, z};
      end
      7'b1101111: begin
        e.ill = 1'b0; e.regw = 1; e.wd = 2'b10; e.ext = 6'b000001; e.cycles = 3 + fw;
        e.npc = 3'b010;
      end
      7'b0110111: begin
        e.ill = 1'b0; e.regw = 1; e.src = 1'b1; e.alu = 5'b00001; e.ext = 6'b000010;
        e.cycles = 4 + fw;
      end
      default: ;
    endcase
    return e;
  endfunction

  // ---------------- monitor ----------------
  int          cyc, nreq, nwe, nir, nmdr, nrw, npcw, fetch_bad, dec_unstable;
  bit          have_dec;
  logic [5:0]  m_ext;
  logic [4:0]  m_alu;
  logic        m_src;
  logic [1:0]  m_wd;
  logic [2:0]  m_npc;

  function automatic void clear_acc();
    cyc = 0; nreq = 0; nwe = 0; nir = 0; nmdr = 0; nrw = 0; npcw = 0;
    fetch_bad = 0; dec_unstable = 0; have_dec = 1'b0;
    m_ext = '0; m_alu = '0; m_src = 1'b0; m_wd = '0; m_npc = '0;
  endfunction

  initial clear_acc();

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_strobes", 32'({mem_req, mem_we, IRWrite, MDRWrite, PCWrite, RegWrite, illegal, retire}), 32'd0);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_instret", instret, 32'd0);
      clear_acc();
    end else begin
      cyc++;
      if (mem_req)  nreq++;
      if (mem_we)   nwe++;
      if (IRWrite)  nir++;
      if (MDRWrite) nmdr++;
      if (RegWrite) nrw++;
      if (PCWrite) begin
        npcw++;
        m_npc = NPCOp;
      end
      if (state == 3'd0) begin
        if (EXTOp != 6'd0 || ALUOp != 5'd0 || ALUSrc || WDSel != 2'd0) fetch_bad++;
      end else if (!have_dec) begin
        have_dec = 1'b1;
        m_ext = EXTOp; m_alu = ALUOp; m_src = ALUSrc; m_wd = WDSel;
      end else if (m_ext != EXTOp || m_alu != ALUOp || m_src != ALUSrc || m_wd != WDSel) begin
        dec_unstable++;
      end
      if (retire || illegal) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("illegal_pulse", 32'(illegal), 32'(e.ill));
          chk("retire_pulse", 32'(retire), 32'(!e.ill));
          chk("cycles", 32'(cyc), 32'(e.cycles));
          chk("mem_req_cycles", 32'(nreq), 32'(e.nreq));
          chk("mem_we_cycles", 32'(nwe), 32'(e.nwe));
          chk("irwrite_count", 32'(nir), 32'd1);
          chk("mdrwrite_count", 32'(nmdr), 32'(e.mdr));
          chk("regwrite_count", 32'(nrw), 32'(e.regw));
          chk("pcwrite_count", 32'(npcw), 32'd1);
          chk("npcop", 32'(m_npc), 32'(e.npc));
          chk("extop", 32'(m_ext), 32'(e.ext));
          chk("aluop", 32'(m_alu), 32'(e.alu));
          chk("alusrc", 32'(m_src), 32'(e.src));
          chk("wdsel", 32'(m_wd), 32'(e.wd));
          chk("decode_zero_in_fetch", 32'(fetch_bad), 32'd0);
          chk("decode_stable", 32'(dec_unstable), 32'd0);
          chk("instret_at_completion", instret, e.instret);
        end
        clear_acc();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_instr(input logic [31:0] w, input logic z, input int fw, input int mw);
    exp_t e;
    int   n;
    bit   is_mem;
    e = model(w, z, fw, mw);
    sb.push_back(e);
    if (!e.ill) model_instret = model_instret + 32'd1;
    is_mem = !e.ill && (w[6:0] == 7'b0000011 || w[6:0] == 7'b0100011);
    Op = w[6:0]; Funct3 = w[14:12]; Funct7 = w[31:25]; Zero = z;
    for (int i = 0; i < fw; i++) begin
      mem_ready = 1'b0;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (is_mem) begin
      n = 0;
      while (!mem_req && n < 8) begin
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      chk("mem_phase_reached", 32'(mem_req), 32'd1);
      for (int i = 0; i < mw; i++) begin
        mem_ready = 1'b0;
        @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    n = 0;
    while (state != 3'd0 && n < 10) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    mem_ready = 1'b0;
    chk("instr_done", 32'(state), 32'd0);
  endtask

  task automatic reset_during_sw();
    int n;
    Op = 7'b0100011; Funct3 = 3'b010; Funct7 = '0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    n = 0;
    while (!mem_req && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sw_mem_we_before_reset", 32'(mem_we), 32'd1);
    chk("instret_nonzero_before_reset", 32'(instret != 32'd0), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_pcwrite", 32'(PCWrite), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_instret", instret, 32'd0);
    model_instret = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("fetch_after_reset", 32'(mem_req), 32'd1);
  endtask

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    logic [6:0]  f7c;
    int          k, c;
    w = $urandom;
    k = int'($urandom_range(0, 8));
    c = int'($urandom_range(0, 3));
    f7c = (c < 2) ? 7'h00 : (c == 2) ? 7'h20 : w[31:25];
    case (k)
      0: begin w[6:0] = 7'b0110011; w[31:25] = f7c; end
      1: begin w[6:0] = 7'b0010011; w[31:25] = f7c; end
      2: begin w[6:0] = 7'b0000011; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010; end
      3: begin w[6:0] = 7'b0100011; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b010; end
      4: begin w[6:0] = 7'b1100011; if ($urandom_range(0, 3) != 0) w[14:12] = 3'b000; end
      5: w[6:0] = 7'b1101111;
      6: w[6:0] = 7'b0110111;
      default: ;
    endcase
    if (w[6:0] == 7'b0010011 && w[14:12] == 3'b001 && w[31:25] == 7'h20) w[31:25] = 7'h00;
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    int          fw, mw;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("first_fetch_req", 32'(mem_req), 32'd1);
    chk("first_state", 32'(state), 32'd0);

    run_instr(32'h002081B3, 1'b0, 0, 0);
    run_instr(32'h0000A183, 1'b0, 0, 2);
    run_instr(32'h00208463, 1'b1, 0, 0);
    run_instr(32'h00208463, 1'b0, 0, 0);
    run_instr(32'hFFFFFFFF, 1'b0, 0, 0);
    run_instr(32'h0000006F, 1'b0, 1, 0);
    reset_during_sw();

    for (int k = 0; k < 250; k++) begin
      w  = gen_word();
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(w, 1'($urandom_range(0, 1)), fw, mw);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("instret_final", instret, model_instret);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
